// File: rtl/axis_image_vip_config.sv
// Shared configuration for the image source/sink VIP and the elastic AXI-Stream pipe.
// Beat layout and stage limits used by axis_elastic_pipe and its testbench.
package axis_image_vip_config;

  localparam int SOURCE_BYTES         = 1;
  localparam int BEAT_DATA_BITS       = SOURCE_BYTES * 8;
  localparam int BEAT_USER_BITS       = 1;
  localparam int AXIS_PIPE_MAX_STAGES = 16;

  typedef struct packed {
    logic [BEAT_DATA_BITS-1:0] data;
    logic                      last;
    logic [BEAT_USER_BITS-1:0] user;
  } axis_beat_t;

  // Worst-case beats held by a pipe of the given depth (skid build holds two per stage).
  function automatic int pipe_capacity(input int stages, input bit skid);
    return skid ? 2 * stages : stages;
  endfunction

endpackage

// File: rtl/axis_pipe_slice.sv
// One register slice of the elastic AXI-Stream pipe: beat in/out with valid/ready.
// AXIS_ELASTIC_PIPE_SKID_EN selects a 2-entry skid slice with a registered upstream ready.
module axis_pipe_slice #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_beat,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_beat,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] main_q;
  logic             main_valid_q;

  assign out_beat  = main_q;
  assign out_valid = main_valid_q;

`ifdef AXIS_ELASTIC_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q;
  logic             skid_valid_q;

  // Ready depends only on local state, which breaks the combinational ready chain.
  assign in_ready = !skid_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        main_valid_q <= in_valid;
        if (in_valid) main_q <= in_beat;
      end
    end else if (in_valid && !skid_valid_q) begin
      skid_q       <= in_beat;
      skid_valid_q <= 1'b1;
    end
  end
`else
  assign in_ready = !main_valid_q || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: payload registers are reset too, so no stale data is visible after a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
    end else if (in_ready) begin
      main_valid_q <= in_valid;
      if (in_valid) main_q <= in_beat;
    end
  end
`endif

endmodule

// File: rtl/axis_elastic_pipe.sv
// Elastic AXI-Stream pipe: STAGES chained register slices with full backpressure and occupancy.
// Define AXIS_ELASTIC_PIPE_SKID_EN to build every slice as a 2-entry skid buffer.
module axis_elastic_pipe
  import axis_image_vip_config::*;
#(
  parameter int STAGES    = 2,
  parameter int DATA_BITS = SOURCE_BYTES * 8,
  parameter int USER_BITS = 1,
  parameter int OCC_BITS  = $clog2(2 * STAGES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] axis_s_data_i,
  input  logic                 axis_s_valid_i,
  output logic                 axis_s_ready_o,
  input  logic                 axis_s_last_i,
  input  logic [USER_BITS-1:0] axis_s_user_i,
  output logic [DATA_BITS-1:0] axis_m_data_o,
  output logic                 axis_m_valid_o,
  input  logic                 axis_m_ready_i,
  output logic                 axis_m_last_o,
  output logic [USER_BITS-1:0] axis_m_user_o,
  output logic [OCC_BITS-1:0]  occupancy_o
);

  localparam int BEAT_BITS = DATA_BITS + 1 + USER_BITS;

  if (STAGES < 1 || STAGES > AXIS_PIPE_MAX_STAGES) begin : g_bad_stages
    $error("axis_elastic_pipe: STAGES must be in 1..%0d", AXIS_PIPE_MAX_STAGES);
  end

  logic                 run_q;
  logic                 s_fire;
  logic                 m_fire;
  logic [OCC_BITS-1:0]  occ_q;
  logic [BEAT_BITS-1:0] s_beat;

  // Holds the input closed for the first cycle after reset so no beat is taken during reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) run_q <= 1'b0;
    else       run_q <= 1'b1;
  end

  assign s_beat = {axis_s_data_i, axis_s_last_i, axis_s_user_i};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [BEAT_BITS-1:0] beat_in;
    logic                 valid_in;
    logic                 ready_in;
    logic [BEAT_BITS-1:0] beat_q;
    logic                 valid_q;
    logic                 ready_out;

    if (k == 0) begin : g_head
      assign beat_in  = s_beat;
      assign valid_in = axis_s_valid_i && run_q;
    end else begin : g_link
      assign beat_in  = g_stage[k-1].beat_q;
      assign valid_in = g_stage[k-1].valid_q;
    end

    if (k == STAGES - 1) begin : g_tail
      assign ready_out = axis_m_ready_i;
    end else begin : g_next
      assign ready_out = g_stage[k+1].ready_in;
    end

    axis_pipe_slice #(.WIDTH(BEAT_BITS)) u_slice (
      .clk      (clk_i),
      .rst      (rst_i),
      .in_beat  (beat_in),
      .in_valid (valid_in),
      .in_ready (ready_in),
      .out_beat (beat_q),
      .out_valid(valid_q),
      .out_ready(ready_out)
    );
  end

  assign axis_s_ready_o = run_q && g_stage[0].ready_in;
  assign axis_m_valid_o = g_stage[STAGES-1].valid_q;
  assign {axis_m_data_o, axis_m_last_o, axis_m_user_o} = g_stage[STAGES-1].beat_q;

  assign s_fire = axis_s_valid_i && axis_s_ready_o;
  assign m_fire = axis_m_valid_o && axis_m_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q <= '0;
    end else begin
      case ({s_fire, m_fire})
        2'b10:   occ_q <= occ_q + OCC_BITS'(1);
        2'b01:   occ_q <= occ_q - OCC_BITS'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_axis_elastic_pipe.sv
// Testbench for axis_elastic_pipe: directed scenarios on a 2-stage pipe plus random traffic
// on 2-, 1- and 5-stage pipes, all checked against a queue-based reference model.
module tb_axis_elastic_pipe;
  import axis_image_vip_config::*;

  localparam int N_INST = 3;
  localparam int ST0    = 2;
  localparam int N_RAND = 10000;
`ifdef AXIS_ELASTIC_PIPE_SKID_EN
  localparam int CAP0 = 2 * ST0;
`else
  localparam int CAP0 = ST0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [7:0] s_data  [N_INST];
  logic       s_valid [N_INST];
  logic       s_last  [N_INST];
  logic [0:0] s_user  [N_INST];
  logic       m_ready [N_INST];
  logic       s_ready [N_INST];
  logic       m_valid [N_INST];
  logic       m_last  [N_INST];
  logic [7:0] m_data  [N_INST];
  logic [0:0] m_user  [N_INST];
  logic [7:0] occ     [N_INST];
  logic       fired_w [N_INST];
  int         acc_w   [N_INST];
  int         out_w   [N_INST];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < N_INST; gi++) begin : g_inst
    localparam int ST = (gi == 0) ? ST0 : ((gi == 1) ? 1 : 5);
    localparam int OB = $clog2(2 * ST + 1);
`ifdef AXIS_ELASTIC_PIPE_SKID_EN
    localparam int CAP = 2 * ST;
`endif

    logic [OB-1:0] occ_l;
    axis_beat_t    q[$];
    bit            stall_q   = 1'b0;
    bit            fired     = 1'b0;
    int            acc_n     = 0;
    int            out_n     = 0;
    int            since_rst = 0;

    axis_elastic_pipe #(.STAGES(ST)) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .axis_s_data_i (s_data[gi]),
      .axis_s_valid_i(s_valid[gi]),
      .axis_s_ready_o(s_ready[gi]),
      .axis_s_last_i (s_last[gi]),
      .axis_s_user_i (s_user[gi]),
      .axis_m_data_o (m_data[gi]),
      .axis_m_valid_o(m_valid[gi]),
      .axis_m_ready_i(m_ready[gi]),
      .axis_m_last_o (m_last[gi]),
      .axis_m_user_o (m_user[gi]),
      .occupancy_o   (occ_l)
    );

    assign occ[gi]     = 8'(occ_l);
    assign fired_w[gi] = fired;
    assign acc_w[gi]   = acc_n;
    assign out_w[gi]   = out_n;

    // Reference model: an in-order queue of accepted beats, updated from observed handshakes.
    always @(negedge clk) begin
      if (rst) begin
        check("rst_m_valid", m_valid[gi], 0);
        check("rst_s_ready", s_ready[gi], 0);
        check("rst_occ", occ[gi], 0);
        q.delete();
        stall_q   = 1'b0;
        fired     = 1'b0;
        since_rst = 0;
      end else begin
        check("mon_occ", occ[gi], q.size());
        if (q.size() == 0) check("mon_empty_valid", m_valid[gi], 0);
        if (stall_q) check("mon_hold_valid", m_valid[gi], 1);
        if (m_valid[gi] && q.size() > 0)
          check("mon_beat", {m_data[gi], m_last[gi], m_user[gi]}, q[0]);
        if (since_rst == 0) check("mon_ready_after_rst", s_ready[gi], 0);
`ifdef AXIS_ELASTIC_PIPE_SKID_EN
        else if (q.size() == CAP) check("mon_full_ready", s_ready[gi], 0);
`else
        else check("mon_ready", s_ready[gi], (q.size() < ST) || m_ready[gi]);
`endif
        fired = s_valid[gi] && s_ready[gi];
        if (m_valid[gi] && m_ready[gi]) begin
          if (q.size() > 0) void'(q.pop_front());
          out_n++;
        end
        if (fired) begin
          q.push_back(axis_beat_t'({s_data[gi], s_last[gi], s_user[gi]}));
          acc_n++;
        end
        stall_q = m_valid[gi] && !m_ready[gi];
        since_rst++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  acc, outs, first_acc, first_out, last_out, peak, acc_c, stale;
    int  got[4];
    int  base_a[N_INST];
    int  base_o[N_INST];
    bit  done;

    for (int i = 0; i < N_INST; i++) begin
      s_data[i] = '0; s_valid[i] = 1'b0; s_last[i] = 1'b0; s_user[i] = '0; m_ready[i] = 1'b0;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    tick();

    // Streaming with an always-ready sink: latency, back-to-back output, occupancy peak.
    acc = 0; outs = 0; first_acc = -1; first_out = -1; last_out = -1; peak = 0;
    for (int c = 0; c < 20; c++) begin
      s_valid[0] = (acc < 8); s_data[0] = 8'(acc + 1); s_last[0] = 1'b0; s_user[0] = '0;
      m_ready[0] = 1'b1;
      @(negedge clk);
      if (int'(occ[0]) > peak) peak = occ[0];
      if (m_valid[0]) begin
        check("t1_data", m_data[0], 8'(outs + 1));
        if (first_out < 0) first_out = c;
        last_out = c;
        outs++;
      end
      if (s_valid[0] && s_ready[0]) begin
        if (first_acc < 0) first_acc = c;
        acc++;
      end
      tick();
    end
    check("t1_latency", first_out - first_acc, ST0);
    check("t1_count", outs, 8);
    check("t1_contiguous", last_out - first_out, 7);
    check("t1_peak_occ", peak, 2);

    // Fill against a stalled sink, then release and drain in order.
    acc = 0;
    s_valid[0] = 1'b0; m_ready[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      s_valid[0] = 1'b1; s_data[0] = 8'(8'h11 + acc);
      @(negedge clk);
      if (m_valid[0]) check("t2_hold_data", m_data[0], 8'h11);
      if (s_valid[0] && s_ready[0]) acc++;
      tick();
    end
    check("t2_accepts", acc, CAP0);
    @(negedge clk);
    check("t2_full_ready", s_ready[0], 0);
    check("t2_full_occ", occ[0], CAP0);
    tick();
    outs = 0;
    for (int c = 0; c < 20; c++) begin
      m_ready[0] = 1'b1;
      s_valid[0] = (acc <= CAP0); s_data[0] = 8'(8'h11 + acc);
      @(negedge clk);
      if (m_valid[0] && m_ready[0]) begin
        check("t2_drain_data", m_data[0], 8'(8'h11 + outs));
        outs++;
      end
      if (s_valid[0] && s_ready[0]) acc++;
      tick();
    end
    check("t2_drain_count", outs, CAP0 + 1);

    // Gapped input with a toggling sink ready.
    acc = 0; outs = 0; acc_c = 0;
    for (int c = 0; c < 30; c++) begin
      m_ready[0] = (c % 2 == 0);
      if (acc == 0) begin
        s_valid[0] = 1'b1; s_data[0] = 8'h0A;
      end else if (acc == 1 && c >= acc_c + 4) begin
        s_valid[0] = 1'b1; s_data[0] = 8'h0B;
      end else begin
        s_valid[0] = 1'b0;
      end
      @(negedge clk);
      if (m_valid[0] && m_ready[0]) begin
        if (outs < 4) got[outs] = m_data[0];
        outs++;
      end
      if (s_valid[0] && s_ready[0]) begin
        acc++;
        acc_c = c;
      end
      tick();
    end
    check("t3_count", outs, 2);
    check("t3_first", got[0], 8'h0A);
    check("t3_second", got[1], 8'h0B);

    // last/user flags on beat 3 of 5 only.
    acc = 0; outs = 0;
    for (int c = 0; c < 20; c++) begin
      m_ready[0] = 1'b1;
      s_valid[0] = (acc < 5); s_data[0] = 8'(8'h21 + acc);
      s_last[0]  = (acc == 2); s_user[0] = 1'(acc == 2);
      @(negedge clk);
      if (m_valid[0] && m_ready[0]) begin
        check("t4_data", m_data[0], 8'(8'h21 + outs));
        check("t4_last", m_last[0], outs == 2);
        check("t4_user", m_user[0], outs == 2);
        outs++;
      end
      if (s_valid[0] && s_ready[0]) acc++;
      tick();
    end
    check("t4_count", outs, 5);
    s_last[0] = 1'b0; s_user[0] = '0;

    // Asynchronous reset with two beats held.
    acc = 0; m_ready[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      s_valid[0] = (acc < 2); s_data[0] = 8'(8'h31 + acc);
      @(negedge clk);
      if (s_valid[0] && s_ready[0]) acc++;
      tick();
    end
    s_valid[0] = 1'b0;
    @(negedge clk);
    check("t5_occ_before", occ[0], 2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t5_rst_m_valid", m_valid[0], 0);
    check("t5_rst_occ", occ[0], 0);
    check("t5_rst_s_ready", s_ready[0], 0);
    tick();
    rst = 1'b0; m_ready[0] = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_valid[0]) stale++;
      tick();
    end
    check("t5_no_stale", stale, 0);
    @(negedge clk);
    check("t5_ready_back", s_ready[0], 1);
    tick();

    // Random valid/ready traffic on all three depths.
    for (int i = 0; i < N_INST; i++) begin
      base_a[i] = acc_w[i];
      base_o[i] = out_w[i];
    end
    done = 1'b0;
    for (int c = 0; c < 60000 && !done; c++) begin
      tick();
      done = 1'b1;
      for (int i = 0; i < N_INST; i++) begin
        if (!(s_valid[i] && !fired_w[i])) begin
          if (acc_w[i] - base_a[i] < N_RAND && $urandom_range(0, 99) < 70) begin
            s_valid[i] = 1'b1;
            s_data[i]  = 8'($urandom);
            s_last[i]  = 1'($urandom);
            s_user[i]  = 1'($urandom);
          end else begin
            s_valid[i] = 1'b0;
          end
        end
        m_ready[i] = ($urandom_range(0, 99) < 65);
        if (acc_w[i] - base_a[i] < N_RAND || s_valid[i] || occ[i] != 0) done = 1'b0;
      end
    end
    check("rand_done", done, 1);
    for (int i = 0; i < N_INST; i++) begin
      check("rand_in_count", acc_w[i] - base_a[i], N_RAND);
      check("rand_out_count", out_w[i] - base_o[i], N_RAND);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
